ctrl_escritura_rtc: RTL

Write-transaction sequencer that sits directly upstream of the write-data decoder `Deco_escribirdato`. On a start pulse it enables the decoder and steps its byte index `cuentaE` from 0 through 4. It drives one multiplexed-bus write cycle per decoded byte to the RTC: even index is an address byte, odd index is a data byte. It stops when the decoder raises `band`, then reports completion with a one-cycle `fin` pulse.

---
 rtl/rtc_pkg.sv | 25 ++
 rtl/ctrl_escritura_rtc_if.sv | 34 +++
 rtl/temporizador_fase.sv | 43 ++++
 rtl/ctrl_escritura_rtc.sv | 117 +++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ============================================================================
// Module   : rtc_pkg
// Brief    : Shared state encoding and constants for the RTC bus sequencers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_REL    = 3'd4,
        ST_FIN    = 3'd5
    } estado_e;

    localparam int unsigned T_FASE_DEF  = 10;
    // cuentaE value at which the write decoder raises band
    localparam logic [2:0]  N_BYTES_ESC = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ctrl_escritura_rtc_if.sv
// ============================================================================
// Module   : ctrl_escritura_rtc_if
// Brief    : Decoder handshake and RTC multiplexed bus of the write sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ctrl_escritura_rtc_if;
    logic       inicio;
    logic [7:0] dato_in;
    logic       band;
    logic       enE;
    logic [2:0] cuentaE;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       ocupado;
    logic       fin;

    modport master (
        input  inicio, dato_in, band,
        output enE, cuentaE, ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, ocupado, fin
    );

    modport slave (
        output inicio, dato_in, band,
        input  enE, cuentaE, ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, ocupado, fin
    );
endinterface

`default_nettype wire

// File: rtl/temporizador_fase.sv
// ============================================================================
// Module   : temporizador_fase
// Brief    : 8-bit bus phase counter; listo_o flags the last cycle of a phase.
// Revision : 1.0
// ============================================================================
`default_nettype none

module temporizador_fase #(
    parameter int unsigned T_FASE = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      listo_o
);
    localparam logic [7:0] C_ULTIMO = 8'(T_FASE - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Saturates at the terminal count so an idle phase keeps listo_o asserted
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && !listo_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign listo_o = (cnt_q == C_ULTIMO);
endmodule

`default_nettype wire

// File: rtl/ctrl_escritura_rtc.sv
// ============================================================================
// Module   : ctrl_escritura_rtc
// Brief    : Steps the write decoder through its bytes and drives one RTC
//            multiplexed-bus write cycle (setup/strobe/hold) per byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_escritura_rtc
    import rtc_pkg::*;
#(
    parameter int unsigned T_FASE = T_FASE_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset,
    ctrl_escritura_rtc_if.master  bus
);
    estado_e    estado_q;
    estado_e    estado_d;
    logic [2:0] cuenta_q;
    logic [2:0] cuenta_d;
    logic [7:0] ad_q;
    logic [7:0] ad_d;
    logic       listo;
    logic       cambio;

    logic w_enE;
    logic w_ad_oe;
    logic w_a_d;
    logic w_cs_n;
    logic w_wr_n;
    logic w_ocupado;
    logic w_fin;

    assign cambio = (estado_d != estado_q);

    temporizador_fase #(
        .T_FASE (T_FASE)
    ) u_fase (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cambio),
        .en_i    (1'b1),
        .listo_o (listo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q <= ST_IDLE;
            cuenta_q <= 3'd0;
            ad_q     <= 8'h00;
        end else begin
            estado_q <= estado_d;
            cuenta_q <= cuenta_d;
            ad_q     <= ad_d;
        end
    end

    // A band seen in SETUP means the decoder is already done: skip the strobe
    always_comb begin
        estado_d = estado_q;
        cuenta_d = cuenta_q;
        ad_d     = ad_q;
        unique case (estado_q)
            ST_IDLE: begin
                if (bus.inicio) begin
                    estado_d = ST_SETUP;
                    cuenta_d = 3'd0;
                end
            end
            ST_SETUP: begin
                ad_d = bus.dato_in;
                if (bus.band) begin
                    estado_d = ST_FIN;
                end else if (listo) begin
                    estado_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (listo) estado_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (listo) estado_d = ST_REL;
            end
            ST_REL: begin
                cuenta_d = cuenta_q + 3'd1;
                estado_d = (cuenta_d == N_BYTES_ESC) ? ST_FIN : ST_SETUP;
            end
            ST_FIN:  estado_d = ST_IDLE;
            default: estado_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ad_oe   = (estado_q == ST_SETUP) || (estado_q == ST_STROBE) ||
                    (estado_q == ST_HOLD);
        w_enE     = w_ad_oe || (estado_q == ST_REL);
        w_cs_n    = !w_ad_oe;
        w_wr_n    = (estado_q != ST_STROBE);
        w_a_d     = w_ad_oe && cuenta_q[0];
        w_ocupado = (estado_q != ST_IDLE);
        w_fin     = (estado_q == ST_FIN);
    end

    assign bus.enE     = w_enE;
    assign bus.cuentaE = cuenta_q;
    assign bus.ad_out  = ad_q;
    assign bus.ad_oe   = w_ad_oe;
    assign bus.a_d     = w_a_d;
    assign bus.cs_n    = w_cs_n;
    assign bus.wr_n    = w_wr_n;
    assign bus.rd_n    = 1'b1;
    assign bus.ocupado = w_ocupado;
    assign bus.fin     = w_fin;
endmodule

`default_nettype wire
